vc_queue: RTL and testbench

VC_QUEUE -- requirements
Module: vc_queue

---
 rtl/queue_pkg.sv | 18 +
 rtl/vc_fifo.sv | 81 ++++++++
 rtl/vc_queue.sv | 70 +++++++
 tb/tb_vc_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared constants and width helpers for the virtual-channel queue.
package queue_pkg;

    localparam int DEF_PL        = 16;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_NUM_VC    = 2;
    localparam int PKT_VALID_BIT = 0;

    // A single channel still needs a one-bit selector port.
    function automatic int vc_w_of(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// One virtual channel: flop-based ring buffer with registered occupancy flags.
module vc_fifo
    import queue_pkg::*;
#(
    parameter int PL       = DEF_PL,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEF_DEPTH - 1,
    localparam int CW      = cw_of(DEPTH),
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [PL-1:0] wr_data,
    input  logic          pop_req,
    output logic [PL-1:0] head,
    output logic [CW-1:0] count,
    output logic          avail,
    output logic          almost_full,
    output logic          full
);

    logic [PL-1:0] mem_q [DEPTH];
    logic [PL-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          avail_q, avail_d;
    logic          af_q, af_d;
    logic          do_wr;
    logic          do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_req && (count_q != '0);
        // A full channel still accepts when the head leaves in the same cycle.
        do_wr    = wr_req && ((count_q != CW'(DEPTH)) || do_pop);
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_wr, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        avail_d = (count_d < CW'(DEPTH));
        af_d    = (count_d >= CW'(AF_LEVEL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            avail_q  <= 1'b1;
            af_q     <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            avail_q  <= avail_d;
            af_q     <= af_d;
        end
    end

    assign head        = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count       = count_q;
    assign avail       = avail_q;
    assign almost_full = af_q;
    assign full        = (count_q == CW'(DEPTH));

endmodule

// File: rtl/vc_queue.sv
// Multi-VC input queue: write demux, drop detection and per-VC output packing.
module vc_queue
    import queue_pkg::*;
#(
    parameter int PL       = DEF_PL,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_VC   = DEF_NUM_VC,
    parameter int AF_LEVEL = DEPTH - 1,
    localparam int VC_W    = vc_w_of(NUM_VC),
    localparam int CW      = cw_of(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PL-1:0]        data_in,
    input  logic [VC_W-1:0]      in_vc,
    input  logic [NUM_VC-1:0]    shift,
    output logic [NUM_VC*PL-1:0] data_out,
    output logic [NUM_VC-1:0]    availability,
    output logic [NUM_VC-1:0]    almost_full,
    output logic [NUM_VC*CW-1:0] count,
    output logic                 drop
);

    logic [NUM_VC-1:0] wr_sel;
    logic [NUM_VC-1:0] full;
    logic              in_range;
    logic              drop_d, drop_q;

    always_comb begin
        wr_sel   = '0;
        in_range = (int'(in_vc) < NUM_VC);
        for (int v = 0; v < NUM_VC; v++) begin
            if (data_in[PKT_VALID_BIT] && in_range && (in_vc == VC_W'(v))) begin
                wr_sel[v] = 1'b1;
            end
        end
        // Only the selected channel can be full-and-not-shifting here.
        drop_d = data_in[PKT_VALID_BIT] && (!in_range || (|(wr_sel & full & ~shift)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop = drop_q;

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        vc_fifo #(
            .PL       (PL),
            .DEPTH    (DEPTH),
            .AF_LEVEL (AF_LEVEL)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .wr_req      (wr_sel[g]),
            .wr_data     (data_in),
            .pop_req     (shift[g]),
            .head        (data_out[g*PL +: PL]),
            .count       (count[g*CW +: CW]),
            .avail       (availability[g]),
            .almost_full (almost_full[g]),
            .full        (full[g])
        );
    end

endmodule

// File: tb/tb_vc_queue.sv
// Bench for vc_queue: directed corner cases plus random traffic against queue-based model.
module tb_vc_queue;

    localparam int PL    = 16;
    localparam int DEPTH = 4;
    localparam int AF    = DEPTH - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = '0;
    logic [0:0]  in_vc = '0;
    logic [1:0]  shift = '0;
    logic [31:0] data_out;
    logic [1:0]  availability;
    logic [1:0]  almost_full;
    logic [5:0]  count;
    logic        drop;

    logic [15:0] data_in1 = '0;
    logic [0:0]  in_vc1 = '0;
    logic [0:0]  shift1 = '0;
    logic [15:0] data_out1;
    logic [0:0]  availability1;
    logic [0:0]  almost_full1;
    logic [2:0]  count1;
    logic        drop1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mq0[$];
    logic [15:0] mq1[$];
    logic        exp_drop = 1'b0;

    always #5 clk = ~clk;

    vc_queue #(.PL(PL), .DEPTH(DEPTH), .NUM_VC(2)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .in_vc        (in_vc),
        .shift        (shift),
        .data_out     (data_out),
        .availability (availability),
        .almost_full  (almost_full),
        .count        (count),
        .drop         (drop)
    );

    vc_queue #(.PL(PL), .DEPTH(DEPTH), .NUM_VC(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in1),
        .in_vc        (in_vc1),
        .shift        (shift1),
        .data_out     (data_out1),
        .availability (availability1),
        .almost_full  (almost_full1),
        .count        (count1),
        .drop         (drop1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_apply(input logic [15:0] d, input logic vc, input logic [1:0] sh);
        int  s0;
        int  s1;
        bit  ok;
        s0 = mq0.size();
        s1 = mq1.size();
        ok = d[0] && ((vc == 1'b0) ? (s0 < DEPTH || sh[0]) : (s1 < DEPTH || sh[1]));
        if (sh[0] && s0 > 0) void'(mq0.pop_front());
        if (sh[1] && s1 > 0) void'(mq1.pop_front());
        if (ok) begin
            if (vc == 1'b0) mq0.push_back(d);
            else mq1.push_back(d);
        end
        exp_drop = d[0] && !ok;
    endtask

    task automatic compare();
        logic [15:0] h0;
        logic [15:0] h1;
        h0 = (mq0.size() > 0) ? mq0[0] : 16'h0000;
        h1 = (mq1.size() > 0) ? mq1[0] : 16'h0000;
        check("head0", 32'(data_out[15:0]), 32'(h0));
        check("head1", 32'(data_out[31:16]), 32'(h1));
        check("count0", 32'(count[2:0]), 32'(mq0.size()));
        check("count1", 32'(count[5:3]), 32'(mq1.size()));
        check("avail0", 32'(availability[0]), 32'(mq0.size() < DEPTH));
        check("avail1", 32'(availability[1]), 32'(mq1.size() < DEPTH));
        check("af0", 32'(almost_full[0]), 32'(mq0.size() >= AF));
        check("af1", 32'(almost_full[1]), 32'(mq1.size() >= AF));
        check("drop", 32'(drop), 32'(exp_drop));
    endtask

    task automatic step(input logic [15:0] d, input logic vc, input logic [1:0] sh);
        data_in = d;
        in_vc   = vc;
        shift   = sh;
        model_apply(d, vc, sh);
        @(posedge clk);
        #1;
        data_in = '0;
        shift   = '0;
        compare();
    endtask

    initial begin
        logic [15:0] d;
        logic        v;

        // Reset and check the idle state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare();

        // Two writes to VC0, first one at the first edge after release.
        step(16'h0001, 1'b0, 2'b00);
        step(16'h0003, 1'b0, 2'b00);
        check("dir_head0", 32'(data_out[15:0]), 32'h0001);
        check("dir_count0", 32'(count[2:0]), 32'd2);

        // Fill VC1, then overflow it.
        for (int i = 0; i < 4; i++) step(16'h0011 + 16'(i * 16), 1'b1, 2'b00);
        check("full_avail1", 32'(availability[1]), 32'd0);
        check("full_af1", 32'(almost_full[1]), 32'd1);
        step(16'h0051, 1'b1, 2'b00);
        check("ovf_drop", 32'(drop), 32'd1);
        step(16'h0000, 1'b0, 2'b00);
        check("ovf_drop_clear", 32'(drop), 32'd0);

        // Pass-through write into a full channel.
        step(16'h00FF, 1'b1, 2'b10);
        check("pt_count1", 32'(count[5:3]), 32'd4);
        check("pt_head1", 32'(data_out[31:16]), 32'h0021);

        // Drain VC0 to one entry and VC1 completely; 00FF comes out last.
        step(16'h0000, 1'b0, 2'b01);
        for (int i = 0; i < 3; i++) step(16'h0000, 1'b0, 2'b10);
        check("last_head1", 32'(data_out[31:16]), 32'h00FF);
        step(16'h0000, 1'b0, 2'b10);

        // Shift both with VC0 at one entry and VC1 empty.
        step(16'h0000, 1'b0, 2'b11);
        check("both_head0", 32'(data_out[15:0]), 32'h0000);
        check("both_count1", 32'(count[5:3]), 32'd0);

        // Invalid packet is neither stored nor dropped.
        step(16'h0010, 1'b0, 2'b00);

        // Single-VC instance: out-of-range VC drops, invalid packet does not.
        data_in1 = 16'h0005;
        in_vc1   = 1'b1;
        step(16'h0000, 1'b0, 2'b00);
        check("vc1_oor_drop", 32'(drop1), 32'd1);
        check("vc1_oor_count", 32'(count1), 32'd0);
        data_in1 = 16'h0004;
        in_vc1   = 1'b0;
        step(16'h0000, 1'b0, 2'b00);
        check("vc1_inv_drop", 32'(drop1), 32'd0);
        check("vc1_inv_count", 32'(count1), 32'd0);
        data_in1 = 16'h0009;
        step(16'h0000, 1'b0, 2'b00);
        data_in1 = '0;
        check("vc1_ok_count", 32'(count1), 32'd1);
        check("vc1_ok_head", 32'(data_out1), 32'h0009);

        // Mid-burst asynchronous reset.
        step(16'h0101, 1'b0, 2'b00);
        step(16'h0201, 1'b0, 2'b00);
        step(16'h0301, 1'b0, 2'b00);
        data_in = 16'h0401;
        #2;
        rst = 1'b1;
        #1;
        mq0.delete();
        mq1.delete();
        exp_drop = 1'b0;
        compare();
        check("rst_vc1_count", 32'(count1), 32'd0);
        data_in = '0;
        @(negedge clk);
        rst = 1'b0;
        step(16'h00A1, 1'b0, 2'b00);
        check("post_rst_head0", 32'(data_out[15:0]), 32'h00A1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 9) < 7);
            d    = 16'($urandom());
            d[0] = v;
            step(d, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
